// File: rtl/ibex_instr_capture_ctrl_if.sv
// Probe, configuration, drain and status signals of the instruction capture controller.
// Pure wiring; no storage and no added latency.
// out_ready_i is the only backpressure input; it travels from master to slave.
interface ibex_instr_capture_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // configuration
    logic                  cfg_arm_i;
    logic [DATA_WIDTH-1:0] cfg_start_pc_i;
    logic [DATA_WIDTH-1:0] cfg_stop_pc_i;
    logic [CNT_W-1:0]      cfg_max_cnt_i;

    // ID-stage probe
    logic                  valid_id_i;
    logic                  err_id_i;
    logic                  is_compressed_id_i;
    logic [DATA_WIDTH-1:0] instr_id_i;
    logic [DATA_WIDTH-1:0] pc_id_i;
    logic                  branch_taken_id_i;
    logic [DATA_WIDTH-1:0] branch_target_id_i;

    // drain port
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_pc_o;
    logic [DATA_WIDTH-1:0] out_instr_o;
    logic [DATA_WIDTH-1:0] out_target_o;
    logic [2:0]            out_flags_o;

    // status
    logic [1:0]            state_o;
    logic [LVL_W-1:0]      fifo_level_o;
    logic [CNT_W-1:0]      captured_cnt_o;
    logic [CNT_W-1:0]      dropped_cnt_o;

    // Controller side.
    modport slave (
        input  cfg_arm_i, cfg_start_pc_i, cfg_stop_pc_i, cfg_max_cnt_i,
        input  valid_id_i, err_id_i, is_compressed_id_i, instr_id_i, pc_id_i,
        input  branch_taken_id_i, branch_target_id_i, out_ready_i,
        output out_valid_o, out_pc_o, out_instr_o, out_target_o, out_flags_o,
        output state_o, fifo_level_o, captured_cnt_o, dropped_cnt_o
    );

    // Core-probe / consumer side.
    modport master (
        output cfg_arm_i, cfg_start_pc_i, cfg_stop_pc_i, cfg_max_cnt_i,
        output valid_id_i, err_id_i, is_compressed_id_i, instr_id_i, pc_id_i,
        output branch_taken_id_i, branch_target_id_i, out_ready_i,
        input  out_valid_o, out_pc_o, out_instr_o, out_target_o, out_flags_o,
        input  state_o, fifo_level_o, captured_cnt_o, dropped_cnt_o
    );
endinterface

// File: rtl/ibex_instr_capture_ctrl.sv
// Captures ID-stage instruction events inside an armed start/stop/count window into a FIFO.
// Latency: an event pushed at edge N appears on out_* right after edge N; outputs are registered-only.
// Backpressure: out_ready_i=0 holds the head; a full FIFO drops events (counted) unless a pop frees a slot.
module ibex_instr_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ibex_instr_capture_ctrl_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] target;
        logic [2:0]            flags;
    } entry_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] start_pc_q, stop_pc_q;
    logic [CNT_W-1:0]      max_cnt_q;
    logic [CNT_W-1:0]      captured_q, dropped_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    entry_t                mem [FIFO_DEPTH];

    logic                  arm_accept;
    logic                  cap_evt;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  stop_hit;
    logic                  max_hit;
    logic                  close_win;
    logic [CNT_W-1:0]      captured_inc;
    logic [CNT_W-1:0]      dropped_inc;
    entry_t                wr_entry;
    entry_t                rd_entry;

    // Event classification, FIFO handshake and window-close decision.
    always_comb begin
        arm_accept   = (state_q == IDLE) && bus.cfg_arm_i;
        cap_evt      = bus.valid_id_i &&
                       (((state_q == ARMED) && (bus.pc_id_i == start_pc_q)) ||
                        (state_q == CAPTURE));
        pop          = (level_q != '0) && bus.out_ready_i;
        // A pop in the same cycle frees the slot the push needs.
        push         = cap_evt && ((level_q < DEPTH_L) || pop);
        drop         = cap_evt && !push;
        captured_inc = (captured_q == '1) ? captured_q : captured_q + CNT_W'(1);
        dropped_inc  = (dropped_q == '1) ? dropped_q : dropped_q + CNT_W'(1);
        // A stop-PC match closes even if the event itself was dropped.
        stop_hit     = cap_evt && (bus.pc_id_i == stop_pc_q);
        max_hit      = push && (max_cnt_q != '0) && (captured_inc == max_cnt_q);
        close_win    = stop_hit || max_hit;
        wr_entry.pc     = bus.pc_id_i;
        wr_entry.instr  = bus.instr_id_i;
        wr_entry.target = bus.branch_target_id_i;
        wr_entry.flags  = {bus.err_id_i, bus.is_compressed_id_i, bus.branch_taken_id_i};
    end

    // Next-state logic for the capture window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm_accept) state_d = ARMED;
            ARMED:   if (cap_evt) state_d = close_win ? DRAIN : CAPTURE;
            CAPTURE: if (close_win) state_d = DRAIN;
            DRAIN:   if (level_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Window configuration, latched only when arming from IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_pc_q <= '0;
            stop_pc_q  <= '0;
            max_cnt_q  <= '0;
        end else if (arm_accept) begin
            start_pc_q <= bus.cfg_start_pc_i;
            stop_pc_q  <= bus.cfg_stop_pc_i;
            max_cnt_q  <= bus.cfg_max_cnt_i;
        end
    end

    // Saturating captured/dropped counters, cleared on each new arm.
    always_ff @(posedge clk_i) begin
        if (rst_i || arm_accept) begin
            captured_q <= '0;
            dropped_q  <= '0;
        end else begin
            if (push) captured_q <= captured_inc;
            if (drop) dropped_q  <= dropped_inc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !push) level_q <= level_q - LVL_W'(1);
        end
    end

    // FIFO storage; contents are qualified by level, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry           = mem[rd_ptr_q];
    assign bus.out_valid_o    = (level_q != '0);
    assign bus.out_pc_o       = rd_entry.pc;
    assign bus.out_instr_o    = rd_entry.instr;
    assign bus.out_target_o   = rd_entry.target;
    assign bus.out_flags_o    = rd_entry.flags;
    assign bus.state_o        = state_q;
    assign bus.fifo_level_o   = level_q;
    assign bus.captured_cnt_o = captured_q;
    assign bus.dropped_cnt_o  = dropped_q;

endmodule

// File: tb/tb_ibex_instr_capture_ctrl.sv
// Directed bench for the instruction capture controller.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
// Consumer readiness is driven per scenario to exercise hold, drop and push/pop paths.
module tb_ibex_instr_capture_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ibex_instr_capture_ctrl_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_W(16)) bus ();

    ibex_instr_capture_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One valid probe event for a single cycle; flags = {err, compressed, branch_taken}.
    task automatic ev(input logic [31:0] pc, input logic [2:0] flags);
        bus.valid_id_i         = 1'b1;
        bus.pc_id_i            = pc;
        bus.instr_id_i         = ~pc;
        bus.branch_target_id_i = pc + 32'h1000;
        bus.err_id_i           = flags[2];
        bus.is_compressed_id_i = flags[1];
        bus.branch_taken_id_i  = flags[0];
        tick();
        bus.valid_id_i         = 1'b0;
        bus.err_id_i           = 1'b0;
        bus.is_compressed_id_i = 1'b0;
        bus.branch_taken_id_i  = 1'b0;
    endtask

    task automatic arm(input logic [31:0] start, input logic [31:0] stop, input logic [15:0] max);
        bus.cfg_start_pc_i = start;
        bus.cfg_stop_pc_i  = stop;
        bus.cfg_max_cnt_i  = max;
        bus.cfg_arm_i      = 1'b1;
        tick();
        bus.cfg_arm_i      = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc [8];

        bus.cfg_arm_i = 1'b0;
        bus.cfg_start_pc_i = '0;
        bus.cfg_stop_pc_i = '0;
        bus.cfg_max_cnt_i = '0;
        bus.valid_id_i = 1'b0;
        bus.err_id_i = 1'b0;
        bus.is_compressed_id_i = 1'b0;
        bus.instr_id_i = '0;
        bus.pc_id_i = '0;
        bus.branch_taken_id_i = 1'b0;
        bus.branch_target_id_i = '0;
        bus.out_ready_i = 1'b1;

        // ---- reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", bus.state_o, 0);
        chk("rst_level", bus.fifo_level_o, 0);
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_capt", bus.captured_cnt_o, 0);
        chk("rst_drop", bus.dropped_cnt_o, 0);

        // ---- basic window 0x80..0x8C, consumer always ready
        arm(32'h80, 32'h8C, 16'd0);
        chk("basic_armed", bus.state_o, 1);
        ev(32'h7C, 3'b000);
        chk("basic_pre_ignored", bus.out_valid_o, 0);
        chk("basic_pre_state", bus.state_o, 1);
        ev(32'h80, 3'b000);
        chk("basic_state_cap", bus.state_o, 2);
        chk("basic_pc80", bus.out_pc_o, 32'h80);
        ev(32'h84, 3'b000);
        chk("basic_pc84", bus.out_pc_o, 32'h84);
        chk("basic_instr84", bus.out_instr_o, ~32'h84);
        ev(32'h88, 3'b000);
        chk("basic_level", bus.fifo_level_o, 1);
        chk("basic_pc88", bus.out_pc_o, 32'h88);
        ev(32'h8C, 3'b000);
        chk("basic_drain", bus.state_o, 3);
        chk("basic_pc8c", bus.out_pc_o, 32'h8C);
        chk("basic_capt", bus.captured_cnt_o, 4);
        ev(32'h90, 3'b000);
        chk("basic_post_empty", bus.out_valid_o, 0);
        chk("basic_post_drain", bus.state_o, 3);
        tick();
        chk("basic_idle", bus.state_o, 0);
        chk("basic_capt_end", bus.captured_cnt_o, 4);

        // ---- count limit max=3, consumer stalled
        bus.out_ready_i = 1'b0;
        arm(32'h100, 32'hFFFF_FFFF, 16'd3);
        chk("max_arm_clears", bus.captured_cnt_o, 0);
        ev(32'h100, 3'b000);
        ev(32'h104, 3'b100);
        chk("max_state_cap", bus.state_o, 2);
        ev(32'h108, 3'b011);
        chk("max_state_drain", bus.state_o, 3);
        chk("max_level3", bus.fifo_level_o, 3);
        ev(32'h10C, 3'b000);
        ev(32'h110, 3'b000);
        ev(32'h114, 3'b000);
        chk("max_level_hold", bus.fifo_level_o, 3);
        chk("max_capt", bus.captured_cnt_o, 3);
        chk("max_drop", bus.dropped_cnt_o, 0);
        chk("max_head_stable", bus.out_pc_o, 32'h100);
        bus.out_ready_i = 1'b1;
        tick();
        chk("max_pc104", bus.out_pc_o, 32'h104);
        chk("max_flags_err", bus.out_flags_o, 3'b100);
        tick();
        chk("max_pc108", bus.out_pc_o, 32'h108);
        chk("max_flags_cb", bus.out_flags_o, 3'b011);
        chk("max_target", bus.out_target_o, 32'h1108);
        tick();
        chk("max_empty", bus.fifo_level_o, 0);
        tick();
        chk("max_idle", bus.state_o, 0);

        // ---- overflow, full push/pop, dropped stop-PC closes
        bus.out_ready_i = 1'b0;
        arm(32'h300, 32'h3FC, 16'd0);
        for (int i = 0; i < 10; i++) ev(32'h300 + 32'(4 * i), 3'b000);
        chk("ovf_level", bus.fifo_level_o, 8);
        chk("ovf_drop", bus.dropped_cnt_o, 2);
        chk("ovf_capt", bus.captured_cnt_o, 8);
        chk("ovf_state", bus.state_o, 2);
        bus.out_ready_i = 1'b1;
        ev(32'h328, 3'b000);
        chk("full_pp_level", bus.fifo_level_o, 8);
        chk("full_pp_drop", bus.dropped_cnt_o, 2);
        chk("full_pp_capt", bus.captured_cnt_o, 9);
        chk("full_pp_head", bus.out_pc_o, 32'h304);
        bus.out_ready_i = 1'b0;
        ev(32'h3FC, 3'b000);
        chk("stop_drop_cnt", bus.dropped_cnt_o, 3);
        chk("stop_drop_state", bus.state_o, 3);
        chk("stop_drop_level", bus.fifo_level_o, 8);
        exp_pc = '{32'h304, 32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C, 32'h328};
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_order%0d", i), bus.out_pc_o, exp_pc[i]);
            tick();
        end
        chk("ovf_empty", bus.out_valid_o, 0);
        tick();
        chk("ovf_idle", bus.state_o, 0);

        // ---- degenerate window start==stop
        arm(32'h200, 32'h200, 16'd0);
        ev(32'h1FC, 3'b000);
        chk("deg_armed", bus.state_o, 1);
        ev(32'h200, 3'b000);
        chk("deg_drain", bus.state_o, 3);
        chk("deg_level", bus.fifo_level_o, 1);
        chk("deg_pc", bus.out_pc_o, 32'h200);
        tick();
        chk("deg_popped", bus.fifo_level_o, 0);
        tick();
        chk("deg_idle", bus.state_o, 0);
        chk("deg_capt", bus.captured_cnt_o, 1);

        // ---- arm ignored in CAPTURE, then reset mid-window with level=5
        bus.out_ready_i = 1'b0;
        arm(32'h400, 32'h4FC, 16'd0);
        for (int i = 0; i < 4; i++) ev(32'h400 + 32'(4 * i), 3'b000);
        arm(32'h500, 32'h410, 16'd2);
        chk("rearm_state", bus.state_o, 2);
        chk("rearm_capt", bus.captured_cnt_o, 4);
        ev(32'h410, 3'b000);
        chk("rearm_cfg_kept", bus.state_o, 2);
        chk("rearm_level", bus.fifo_level_o, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", bus.state_o, 0);
        chk("mid_rst_level", bus.fifo_level_o, 0);
        chk("mid_rst_valid", bus.out_valid_o, 0);
        chk("mid_rst_capt", bus.captured_cnt_o, 0);
        chk("mid_rst_drop", bus.dropped_cnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
